npu_dma_arbiter: RTL and testbench
==================================

Name: npu_dma_arbiter

Overview:
Shares the single shell DMA request channel (dma_req_valid/src/dst/bytes, dma_req_ready, dma_resp_done) between NUM_REQ requesters. Typical requesters are the command-queue DMA_COPY path and GEMM operand prefetch.
Uses round-robin arbitration with at most one transfer in flight. Routes the completion pulse back to the owning requester.
Sits inside npu_top, between the requesters and the AXI DMA shim.

Parameters:
NUM_REQ, 2, number of requesters (>=2).
ID_W, $clog2(NUM_REQ), width of the grant index.
TIMEOUT_CYCLES, 4096, watchdog limit in cycles (used only with NPU_DMA_ARB_TIMEOUT_EN).

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_src  in  NUM_REQ*64  source address, requester i at [i*64 +: 64].
req_dst  in  NUM_REQ*64  destination address, same packing as req_src.
req_bytes  in  NUM_REQ*32  transfer length in bytes.
req_ready  out  NUM_REQ  request accepted (one-hot).
resp_done  out  NUM_REQ  one-cycle completion pulse to the owner.
dma_req_valid  out  1  downstream request valid.
dma_req_src  out  64  latched source address.
dma_req_dst  out  64  latched destination address.
dma_req_bytes  out  32  latched length.
dma_req_ready  in  1  downstream accept.
dma_resp_done  in  1  downstream completion pulse.
busy  out  1  transfer owned (state != IDLE).
grant_id  out  ID_W  current owner index.
timeout_err  out  1  sticky watchdog error.
err_clr  in  1  clears timeout_err.

Behaviour:
- Reset: state=IDLE, rr_ptr=0. All outputs are 0, including latched fields and grant_id.
- Reset mid-operation: any in-flight downstream transfer is abandoned and no resp_done is generated.
- FSM states: IDLE, ISSUE, WAIT, ZDONE.
- IDLE, winner selection: the winner is the first asserted req_valid scanning from rr_ptr upward with wrap.
- IDLE, acceptance: req_ready[winner]=1 combinationally in the same cycle, so acceptance is valid&ready.
- IDLE, on acceptance: latch src/dst/bytes and grant_id=winner.
- IDLE, next state: bytes==0 -> ZDONE; otherwise -> ISSUE.
- IDLE with no req_valid: all req_ready=0.
- ISSUE: dma_req_valid=1 and dma_req_* held stable. On dma_req_ready go to WAIT.
- ISSUE, simultaneous dma_req_ready and dma_resp_done: treated as accept plus complete, same action as done in WAIT.
- WAIT: on dma_resp_done, resp_done[grant_id]=1 for one cycle (registered), rr_ptr=(grant_id+1) mod NUM_REQ, go to IDLE.
- ZDONE: resp_done[grant_id]=1 for one cycle, rr_ptr advances as in WAIT, go to IDLE. No downstream request is issued.
- req_ready is 0 in every state except IDLE.
- dma_resp_done is ignored in IDLE and ZDONE, and in ISSUE without dma_req_ready.
- Latency: accept at cycle T -> dma_req_valid at T+1.
- Latency: dma_resp_done at cycle D -> resp_done at D+1. The next grant is possible at D+1 (IDLE decision in that same cycle).
- The rr_ptr advance guarantees no requester waits more than NUM_REQ-1 transfers.
- The latched fields keep their value after completion until the next acceptance.

Optional Feature:
NPU_DMA_ARB_TIMEOUT_EN defined:
- A 32-bit counter clears on entering ISSUE and increments in ISSUE and WAIT.
- When the counter reaches TIMEOUT_CYCLES, timeout_err is set to 1.
- timeout_err is sticky until err_clr or rst. err_clr has priority if it coincides with a new timeout.
- The FSM keeps waiting; no forced completion.
NPU_DMA_ARB_TIMEOUT_EN undefined:
- No counter is built.
- timeout_err is tied to 0 and err_clr is unused.

Decomposition:
- Package npu_dma_arb_pkg holds: the state enum (IDLE, ISSUE, WAIT, ZDONE), DMA_ADDR_W=64, DMA_LEN_W=32, and a dma_req_t struct {src, dst, bytes}.
- One sub-module, npu_rr_arb: combinational round-robin pick taking valid[NUM_REQ] and ptr[ID_W], and producing a one-hot grant and its index.

Test Plan:
- Single request: req0 with src=0x0, dst=0x100000, bytes=4096. Expect dma_req_* to match one cycle after acceptance. Hold dma_req_ready low 3 cycles -> fields stable. Pulse done -> resp_done=2'b01 exactly one cycle later.
- Contention: req0 and req1 held valid from reset, 4 transfers. Expect grant order 0,1,0,1 and exactly one resp_done pulse per transfer, to the correct owner.
- Zero length: req1 bytes=0. Expect dma_req_valid never asserted and resp_done=2'b10 two cycles after acceptance.
- Reset mid-WAIT: assert rst for 1 cycle. Expect busy=0, dma_req_valid=0, no resp_done. A following req0 is granted first (rr_ptr=0).
- Timeout build, TIMEOUT_CYCLES=16, dma_resp_done withheld: timeout_err rises 16 cycles after ISSUE entry. err_clr drops it. A later done still completes normally.
- Simultaneous ready and done in ISSUE: resp_done is asserted the next cycle and the FSM returns to IDLE.

Source files
------------

// File: rtl/npu_dma_arb_pkg.sv
// Shared types and widths for the NPU shell DMA arbiter.
package npu_dma_arb_pkg;

  localparam int unsigned DMA_ADDR_W = 64;
  localparam int unsigned DMA_LEN_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ZDONE = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] src;
    logic [DMA_ADDR_W-1:0] dst;
    logic [DMA_LEN_W-1:0]  bytes;
  } dma_req_t;

endpackage

// File: rtl/npu_rr_arb.sv
// Combinational round-robin pick: first asserted valid scanning upward from ptr with wrap.
module npu_rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [ID_W-1:0]    idx_c,
  output logic               any_c
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!any_c && valid[cand]) begin
        any_c         = 1'b1;
        grant_c[cand] = 1'b1;
        idx_c         = cand;
      end
    end
  end

endmodule

// File: rtl/npu_dma_arbiter.sv
// Round-robin sharing of the single shell DMA channel, one transfer in flight.
// Optional watchdog built when NPU_DMA_ARB_TIMEOUT_EN is defined.
module npu_dma_arbiter
  import npu_dma_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ID_W           = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DMA_ADDR_W-1:0] req_src,
  input  logic [NUM_REQ*DMA_ADDR_W-1:0] req_dst,
  input  logic [NUM_REQ*DMA_LEN_W-1:0]  req_bytes,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_done,
  output logic                          dma_req_valid,
  output logic [DMA_ADDR_W-1:0]         dma_req_src,
  output logic [DMA_ADDR_W-1:0]         dma_req_dst,
  output logic [DMA_LEN_W-1:0]          dma_req_bytes,
  input  logic                          dma_req_ready,
  input  logic                          dma_resp_done,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          timeout_err,
  input  logic                          err_clr
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  dma_req_t         lat_q, lat_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  dma_req_t           req_a [NUM_REQ];
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic [ID_W-1:0]    next_ptr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_a[g].src   = req_src[g*DMA_ADDR_W +: DMA_ADDR_W];
    assign req_a[g].dst   = req_dst[g*DMA_ADDR_W +: DMA_ADDR_W];
    assign req_a[g].bytes = req_bytes[g*DMA_LEN_W +: DMA_LEN_W];
  end

  npu_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arb (
    .valid   (req_valid),
    .ptr     (rr_q),
    .grant_c (arb_grant),
    .idx_c   (arb_idx),
    .any_c   (arb_any)
  );

  // Owner after the current one gets first pick next time.
  assign next_ptr = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(grant_q + 1'b1);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    lat_d     = lat_q;
    done_d    = '0;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          grant_d   = arb_idx;
          lat_d     = req_a[arb_idx];
          state_d   = (req_a[arb_idx].bytes == '0) ? ZDONE : ISSUE;
        end
      end
      ISSUE: begin
        if (dma_req_ready) begin
          if (dma_resp_done) begin
            done_d[grant_q] = 1'b1;
            rr_d            = next_ptr;
            state_d         = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dma_resp_done) begin
          done_d[grant_q] = 1'b1;
          rr_d            = next_ptr;
          state_d         = IDLE;
        end
      end
      ZDONE: begin
        done_d[grant_q] = 1'b1;
        rr_d            = next_ptr;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      lat_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
    end
  end

  assign dma_req_valid = (state_q == ISSUE);
  assign dma_req_src   = lat_q.src;
  assign dma_req_dst   = lat_q.dst;
  assign dma_req_bytes = lat_q.bytes;
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_q;
  assign resp_done     = done_q;

`ifdef NPU_DMA_ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // Watchdog: cleared on ISSUE entry, counts while a transfer is outstanding.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == IDLE && state_d == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == ISSUE || state_q == WAIT) begin
      cnt_d = cnt_q + 32'd1;
      if (cnt_d == 32'(TIMEOUT_CYCLES)) err_d = 1'b1;
    end
    if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr ^ (TIMEOUT_CYCLES == 0);
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_npu_dma_arbiter.sv
// Self-checking bench for npu_dma_arbiter: directed scenarios plus randomized traffic vs a transaction model.
module tb_npu_dma_arbiter;

  localparam int unsigned N   = 2;
  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned TO  = 16;
`ifdef NPU_DMA_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid;
  logic [63:0] src [N];
  logic [63:0] dst [N];
  logic [31:0] len [N];
  logic [N*64-1:0] req_src, req_dst;
  logic [N*32-1:0] req_bytes;
  logic [N-1:0] req_ready, resp_done;
  logic dma_req_valid, dma_req_ready, dma_resp_done, busy, timeout_err, err_clr;
  logic [63:0] dma_req_src, dma_req_dst;
  logic [31:0] dma_req_bytes;
  logic [IDW-1:0] grant_id;

  int vec  = 0;
  int errs = 0;

  assign req_src   = {src[1], src[0]};
  assign req_dst   = {dst[1], dst[0]};
  assign req_bytes = {len[1], len[0]};

  always #5 clk = ~clk;

  npu_dma_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_src(req_src), .req_dst(req_dst),
    .req_bytes(req_bytes), .req_ready(req_ready), .resp_done(resp_done),
    .dma_req_valid(dma_req_valid), .dma_req_src(dma_req_src), .dma_req_dst(dma_req_dst),
    .dma_req_bytes(dma_req_bytes), .dma_req_ready(dma_req_ready), .dma_resp_done(dma_resp_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; dma_req_ready = 1'b0; dma_resp_done = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    @(negedge clk);
    vec++; if ({req_ready, resp_done, dma_req_valid, busy, grant_id, timeout_err} !== '0) begin
      errs++; $display("FAIL reset_ctrl got rdy=%b done=%b v=%b busy=%b gid=%0d err=%b want all 0",
                       req_ready, resp_done, dma_req_valid, busy, grant_id, timeout_err); end
    vec++; if ({dma_req_src, dma_req_dst, dma_req_bytes} !== '0) begin
      errs++; $display("FAIL reset_fields got %h/%h/%h want 0", dma_req_src, dma_req_dst, dma_req_bytes); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    src[0] = 64'h0; dst[0] = 64'h100000; len[0] = 32'd4096; req_valid = 2'b01;
    @(negedge clk);
    vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL single_accept got %b want 01", req_ready); end
    for (int i = 0; i < 3; i++) begin
      step(); req_valid = '0;
      @(negedge clk);
      vec++; if ({dma_req_valid, dma_req_src, dma_req_dst, dma_req_bytes, grant_id} !== {1'b1, 64'h0, 64'h100000, 32'd4096, 1'b0}) begin
        errs++; $display("FAIL single_hold%0d got v=%b %h %h %0d gid=%0d want 1 0 100000 4096 0",
                         i, dma_req_valid, dma_req_src, dma_req_dst, dma_req_bytes, grant_id); end
    end
    step(); dma_req_ready = 1'b1;
    @(negedge clk);
    vec++; if (dma_req_valid !== 1'b1) begin errs++; $display("FAIL single_issue got %b want 1", dma_req_valid); end
    step(); dma_req_ready = 1'b0;
    @(negedge clk);
    vec++; if ({dma_req_valid, busy} !== 2'b01) begin errs++; $display("FAIL single_wait got v=%b busy=%b want 0 1", dma_req_valid, busy); end
    step(); dma_resp_done = 1'b1;
    @(negedge clk);
    vec++; if (resp_done !== 2'b00) begin errs++; $display("FAIL single_early_done got %b want 00", resp_done); end
    step(); dma_resp_done = 1'b0;
    @(negedge clk);
    vec++; if ({resp_done, busy, dma_req_bytes} !== {2'b01, 1'b0, 32'd4096}) begin
      errs++; $display("FAIL single_done got done=%b busy=%b bytes=%0d want 01 0 4096", resp_done, busy, dma_req_bytes); end
    step();
    @(negedge clk);
    vec++; if (resp_done !== 2'b00) begin errs++; $display("FAIL single_pulse_width got %b want 00", resp_done); end
  endtask

  task automatic test_contention();
    int grants[$];
    int pulses [N];
    int owner;
    int total;
    logic pend;
    logic [N-1:0] exp_v;
    do_reset();
    for (int i = 0; i < int'(N); i++) begin
      src[i] = 64'(i) << 20; dst[i] = 64'h8000 + 64'(i); len[i] = 32'(64 * (i + 1)); pulses[i] = 0;
    end
    req_valid = '1; owner = -1; total = 0; pend = 1'b0;
    for (int c = 0; c < 80 && total < 4; c++) begin
      if (c != 0) step();
      dma_resp_done = pend;
      dma_req_ready = dma_req_valid;
      pend = dma_req_valid;
      @(negedge clk);
      if (resp_done != '0) begin
        exp_v = '0;
        if (owner >= 0) exp_v[owner] = 1'b1;
        vec++; if (resp_done !== exp_v) begin errs++; $display("FAIL cont_owner got %b want %b", resp_done, exp_v); end
        for (int i = 0; i < int'(N); i++) if (resp_done[i]) pulses[i]++;
        total++;
      end
      for (int i = 0; i < int'(N); i++) if (req_ready[i]) begin grants.push_back(i); owner = i; end
    end
    vec++; if (total != 4) begin errs++; $display("FAIL cont_budget got %0d completions want 4", total); end
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (k >= grants.size()) begin errs++; $display("FAIL cont_order%0d got none want %0d", k, k % 2); end
      else if (grants[k] != k % 2) begin errs++; $display("FAIL cont_order%0d got %0d want %0d", k, grants[k], k % 2); end
    end
    vec++; if (pulses[0] != 2 || pulses[1] != 2) begin
      errs++; $display("FAIL cont_pulses got %0d/%0d want 2/2", pulses[0], pulses[1]); end
    idle_inputs();
  endtask

  task automatic test_zero_len();
    do_reset();
    src[1] = 64'hABC0; dst[1] = 64'hDEF0; len[1] = 32'd0; req_valid = 2'b10;
    @(negedge clk);
    vec++; if (req_ready !== 2'b10) begin errs++; $display("FAIL zero_accept got %b want 10", req_ready); end
    step(); req_valid = '0;
    @(negedge clk);
    vec++; if ({dma_req_valid, busy, grant_id, resp_done, dma_req_src} !== {1'b0, 1'b1, 1'b1, 2'b00, 64'hABC0}) begin
      errs++; $display("FAIL zero_t1 got v=%b busy=%b gid=%0d done=%b src=%h want 0 1 1 00 abc0",
                       dma_req_valid, busy, grant_id, resp_done, dma_req_src); end
    step();
    @(negedge clk);
    vec++; if ({resp_done, dma_req_valid, busy} !== {2'b10, 1'b0, 1'b0}) begin
      errs++; $display("FAIL zero_done got done=%b v=%b busy=%b want 10 0 0", resp_done, dma_req_valid, busy); end
    step();
    @(negedge clk);
    vec++; if (resp_done !== 2'b00) begin errs++; $display("FAIL zero_pulse_width got %b want 00", resp_done); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    src[1] = 64'h1234; dst[1] = 64'h5678; len[1] = 32'd64; req_valid = 2'b10;
    @(negedge clk);
    vec++; if (req_ready !== 2'b10) begin errs++; $display("FAIL rstw_accept got %b want 10", req_ready); end
    step(); req_valid = '0; dma_req_ready = 1'b1;
    step(); dma_req_ready = 1'b0;
    @(negedge clk);
    vec++; if ({busy, dma_req_valid} !== 2'b10) begin errs++; $display("FAIL rstw_wait got busy=%b v=%b want 1 0", busy, dma_req_valid); end
    step(); rst = 1'b1;
    step(); rst = 1'b0; dma_resp_done = 1'b1;
    @(negedge clk);
    vec++; if ({busy, dma_req_valid, resp_done, dma_req_src, dma_req_bytes} !== '0) begin
      errs++; $display("FAIL rstw_after got busy=%b v=%b done=%b src=%h bytes=%0d want all 0",
                       busy, dma_req_valid, resp_done, dma_req_src, dma_req_bytes); end
    step(); dma_resp_done = 1'b0; len[0] = 32'd16; len[1] = 32'd16; req_valid = 2'b11;
    @(negedge clk);
    vec++; if ({resp_done, req_ready} !== {2'b00, 2'b01}) begin
      errs++; $display("FAIL rstw_regrant got done=%b rdy=%b want 00 01", resp_done, req_ready); end
    step(); idle_inputs();
  endtask

  task automatic test_simul();
    do_reset();
    len[0] = 32'd8; req_valid = 2'b01;
    @(negedge clk);
    vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL simul_accept got %b want 01", req_ready); end
    step(); req_valid = '0; dma_req_ready = 1'b1; dma_resp_done = 1'b1;
    @(negedge clk);
    vec++; if (dma_req_valid !== 1'b1) begin errs++; $display("FAIL simul_issue got %b want 1", dma_req_valid); end
    step(); idle_inputs(); len[1] = 32'd8; req_valid = 2'b10;
    @(negedge clk);
    vec++; if ({resp_done, busy, dma_req_valid, req_ready} !== {2'b01, 1'b0, 1'b0, 2'b10}) begin
      errs++; $display("FAIL simul_done got done=%b busy=%b v=%b rdy=%b want 01 0 0 10",
                       resp_done, busy, dma_req_valid, req_ready); end
    step(); idle_inputs();
  endtask

  task automatic test_timeout();
    logic exp_e;
    do_reset();
    len[0] = 32'd32; req_valid = 2'b01;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      step(); req_valid = '0;
      @(negedge clk);
      exp_e = TO_EN && (k >= int'(TO));
      vec++; if (timeout_err !== exp_e) begin errs++; $display("FAIL timeout_k%0d got %b want %b", k, timeout_err, exp_e); end
    end
    step(); err_clr = 1'b1;
    @(negedge clk);
    vec++; if (timeout_err !== TO_EN) begin errs++; $display("FAIL timeout_sticky got %b want %b", timeout_err, TO_EN); end
    step(); err_clr = 1'b0;
    @(negedge clk);
    vec++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL timeout_clr got %b want 0", timeout_err); end
    step(); dma_req_ready = 1'b1;
    step(); dma_req_ready = 1'b0; dma_resp_done = 1'b1;
    step(); dma_resp_done = 1'b0;
    @(negedge clk);
    vec++; if ({resp_done, busy, timeout_err} !== {2'b01, 1'b0, 1'b0}) begin
      errs++; $display("FAIL timeout_complete got done=%b busy=%b err=%b want 01 0 0", resp_done, busy, timeout_err); end
  endtask

  // Transaction-level model: owner of the channel, whether its request is still unaccepted downstream.
  task automatic test_random();
    int own, rr, win;
    bit m_issue, m_zero;
    logic [N-1:0] m_pend, nxt_pend, exp_ready, drop;
    logic [63:0] m_src, m_dst;
    logic [31:0] m_bytes;
    logic [IDW-1:0] m_gid;
    do_reset();
    own = -1; rr = 0; m_issue = 0; m_zero = 0; m_pend = '0; drop = '0;
    m_src = '0; m_dst = '0; m_bytes = '0; m_gid = '0;
    for (int c = 0; c < 600; c++) begin
      if (c != 0) step();
      for (int i = 0; i < int'(N); i++) begin
        if (drop[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          src[i] = {$urandom, $urandom}; dst[i] = {$urandom, $urandom};
          len[i] = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
        end
      end
      dma_req_ready = 1'($urandom_range(0, 1));
      dma_resp_done = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      win = -1; exp_ready = '0;
      if (own < 0)
        for (int k = 0; k < int'(N); k++)
          if (win < 0 && req_valid[(rr + k) % int'(N)]) win = (rr + k) % int'(N);
      if (win >= 0) exp_ready[win] = 1'b1;
      vec++; if (req_ready !== exp_ready) begin errs++; $display("FAIL rnd_ready c=%0d got %b want %b", c, req_ready, exp_ready); end
      vec++; if ({dma_req_valid, busy, resp_done} !== {m_issue, own >= 0, m_pend}) begin
        errs++; $display("FAIL rnd_ctrl c=%0d got v=%b busy=%b done=%b want %b %b %b",
                         c, dma_req_valid, busy, resp_done, m_issue, own >= 0, m_pend); end
      vec++; if ({dma_req_src, dma_req_dst, dma_req_bytes, grant_id} !== {m_src, m_dst, m_bytes, m_gid}) begin
        errs++; $display("FAIL rnd_fields c=%0d got %h %h %h %0d want %h %h %h %0d",
                         c, dma_req_src, dma_req_dst, dma_req_bytes, grant_id, m_src, m_dst, m_bytes, m_gid); end
      drop = exp_ready;
      nxt_pend = '0;
      if (own < 0) begin
        if (win >= 0) begin
          own = win; m_gid = IDW'(win);
          m_src = src[win]; m_dst = dst[win]; m_bytes = len[win];
          if (len[win] == 0) m_zero = 1; else m_issue = 1;
        end
      end else if (m_zero || (m_issue && dma_req_ready && dma_resp_done) || (!m_issue && dma_resp_done)) begin
        nxt_pend[own] = 1'b1; rr = (own + 1) % int'(N); own = -1; m_zero = 0; m_issue = 0;
      end else if (m_issue && dma_req_ready) begin
        m_issue = 0;
      end
      m_pend = nxt_pend;
    end
    step(); idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) begin src[i] = '0; dst[i] = '0; len[i] = '0; end
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_zero_len();
    test_reset_mid_wait();
    test_simul();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
